// File: rtl/ofdm_sym_sched.sv
// Orders QPSK-mapped samples into 64-bin OFDM symbols (k = -32..+31), inserting
// null bins and LFSR-scrambled BPSK pilots ahead of the IFFT.
module ofdm_sym_sched #(
  parameter logic [15:0] PILOT_POS = 16'h7FFF,
  parameter logic [15:0] PILOT_NEG = 16'h8001
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_t;
  typedef enum logic [1:0] {SLOT_NULL = 2'd0, SLOT_PILOT = 2'd1, SLOT_DATA = 2'd2} slot_t;

  localparam logic [6:0] LFSR_SEED = 7'b1111111;

  state_t      state, state_nx;
  slot_t       slot;
  logic [5:0]  pos, pos_nx;
  logic [6:0]  lfsr, lfsr_nx;
  logic [31:0] dat, dat_nx;
  logic        stb, stb_nx, cyc, cyc_nx;
  logic        in_ok, halt, pol, flushing, ack, adv;

  function automatic slot_t slot_of(input logic [5:0] p);
    slot_t s;
    case (p)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd32,
      6'd59, 6'd60, 6'd61, 6'd62, 6'd63: s = SLOT_NULL;
      6'd11, 6'd25, 6'd39, 6'd53:        s = SLOT_PILOT;
      default:                           s = SLOT_DATA;
    endcase
    return s;
  endfunction

  // Only the pilot at bin +21 (pos 53) has a negative base sign.
  function automatic logic [31:0] pilot_of(input logic [5:0] p, input logic inv);
    logic neg;
    neg = (p == 6'd53) ^ inv;
    return {16'h0000, (neg ? PILOT_NEG : PILOT_POS)};
  endfunction

  assign in_ok    = CYC_I & STB_I & WE_I;
  assign halt     = stb & ~ACK_I;
  assign pol      = lfsr[6] ^ lfsr[3];
  assign slot     = slot_of(pos);
  // Frame end is not honoured at pos 0: a symbol that just wrapped still starts before flushing.
  assign flushing = (state == FLUSH) || ((state == RUN) && !CYC_I && (pos != 6'd0));

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    lfsr_nx  = lfsr;
    dat_nx   = dat;
    stb_nx   = stb;
    cyc_nx   = cyc;
    ack      = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        if (CYC_I) begin
          state_nx = RUN;
          cyc_nx   = 1'b1;
          pos_nx   = 6'd0;
          lfsr_nx  = LFSR_SEED;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN, FLUSH: begin
        state_nx = flushing ? FLUSH : state;
        if (!halt) begin
          case (slot)
            SLOT_NULL: begin
              dat_nx = 32'h0000_0000;
              stb_nx = 1'b1;
              adv    = 1'b1;
            end
            SLOT_PILOT: begin
              dat_nx = pilot_of(pos, pol);
              stb_nx = 1'b1;
              adv    = 1'b1;
            end
            SLOT_DATA: begin
              if (flushing) begin
                dat_nx = 32'h0000_0000;
                stb_nx = 1'b1;
                adv    = 1'b1;
              end else if (in_ok) begin
                ack    = 1'b1;
                dat_nx = DAT_I;
                stb_nx = 1'b1;
                adv    = 1'b1;
              end else begin
                stb_nx = 1'b0;
              end
            end
            default: stb_nx = 1'b0;
          endcase
        end else begin
          stb_nx = stb;
        end
        // Symbol boundary: advance pilot polarity, then either wrap or close the frame.
        if (adv && (pos == 6'd63)) begin
          pos_nx   = 6'd0;
          lfsr_nx  = {lfsr[5:0], pol};
          state_nx = flushing ? DRAIN : RUN;
        end else if (adv) begin
          pos_nx = pos + 6'd1;
        end else begin
          pos_nx = pos;
        end
      end
      DRAIN: begin
        if (stb && ACK_I) begin
          stb_nx   = 1'b0;
          cyc_nx   = 1'b0;
          state_nx = IDLE;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= IDLE;
      pos   <= 6'd0;
      lfsr  <= LFSR_SEED;
      dat   <= 32'h0000_0000;
      stb   <= 1'b0;
      cyc   <= 1'b0;
    end else begin
      state <= state_nx;
      pos   <= pos_nx;
      lfsr  <= lfsr_nx;
      dat   <= dat_nx;
      stb   <= stb_nx;
      cyc   <= cyc_nx;
    end
  end

  assign ACK_O = ack;
  assign DAT_O = dat;
  assign CYC_O = cyc;
  assign STB_O = stb;
  assign WE_O  = stb;

endmodule

// File: tb/tb_ofdm_sym_sched.sv
// Randomised bench for ofdm_sym_sched: a symbol-level scoreboard rebuilds every
// output sample from the slot map, the pilot polarity sequence and the accepted inputs.
module tb_ofdm_sym_sched;

  localparam logic [15:0] PPOS = 16'h7FFF;
  localparam logic [15:0] PNEG = 16'h8001;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [31:0] DAT_I = 32'h0;
  logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0, ACK_I = 1'b0;
  logic        ACK_O, CYC_O, STB_O, WE_O;
  logic [31:0] DAT_O;

  ofdm_sym_sched #(.PILOT_POS(PPOS), .PILOT_NEG(PNEG)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Scoreboard state
  logic [31:0] q[$];
  int          mpos = 0, msym = 0, ack_total = 0, frame_stb = 0, frame_bub = 0;
  bit          low_seen = 0, pres_low = 0, held_prev = 0, gap_exp = 0, end_exp = 0, cyc_prev = 0;
  logic [31:0] dat_prev = 32'h0;
  bit          p_tab[32];
  logic [15:0] pil_log[32][4];

  // Pilot polarity per symbol: x7^x4 of a 7-bit LFSR seeded all-ones, shifting p in.
  initial begin
    int r, pb;
    r = 127;
    for (int s = 0; s < 32; s++) begin
      pb = ((r >> 6) ^ (r >> 3)) & 1;
      p_tab[s] = pb[0];
      r = ((r << 1) | pb) & 127;
    end
  end

  initial begin
    bit          low_now, frame_end, neg;
    logic [31:0] exp_v;
    forever begin
      @(negedge CLK_I);
      if (RST_I) begin
        q.delete();
        mpos = 0; msym = 0; low_seen = 0; pres_low = 0; held_prev = 0;
        gap_exp = 0; end_exp = 0; dat_prev = 32'h0; cyc_prev = 0;
      end else begin
        low_now   = low_seen | (CYC_O & ~CYC_I);
        frame_end = 0;
        chk("we_eq_stb", {31'd0, WE_O}, {31'd0, STB_O});
        if (held_prev) chk("hold_halt", DAT_O, dat_prev);
        if (!STB_O) chk("hold_nostb", DAT_O, dat_prev);
        if (STB_O && !ACK_I) chk("ack_halt", {31'd0, ACK_O}, 32'd0);
        if (ACK_O) chk("ack_inok", {31'd0, CYC_I & STB_I & WE_I}, 32'd1);
        if (!CYC_O) chk("ack_nocyc", {31'd0, ACK_O}, 32'd0);
        if (gap_exp) begin chk("no_gap", {31'd0, STB_O}, 32'd1); gap_exp = 0; end
        if (end_exp) begin chk("cyc_fall", {30'd0, CYC_O, STB_O}, 32'd0); end_exp = 0; end
        if (STB_O && !held_prev) pres_low = low_seen;
        if (STB_O && ACK_I) begin
          if (mpos < 6 || mpos == 32 || mpos > 58) begin
            exp_v = 32'h0;
          end else if (mpos == 11 || mpos == 25 || mpos == 39 || mpos == 53) begin
            neg   = (mpos == 53) ^ p_tab[msym % 32];
            exp_v = {16'h0000, (neg ? PNEG : PPOS)};
            pil_log[msym % 32][(mpos - 11) / 14] = DAT_O[15:0];
          end else if (q.size() > 0) begin
            exp_v = q.pop_front();
          end else begin
            chk($sformatf("flush_allowed s%0d p%0d", msym, mpos), {31'd0, pres_low}, 32'd1);
            exp_v = 32'h0;
          end
          chk($sformatf("sample s%0d p%0d", msym, mpos), DAT_O, exp_v);
          mpos++;
          if (mpos == 64) begin
            mpos = 0;
            if (pres_low) begin end_exp = 1; frame_end = 1; msym = 0; end
            else begin gap_exp = 1; msym++; end
          end
        end
        if (ACK_O) begin q.push_back(DAT_I); ack_total++; end
        if (CYC_O && !cyc_prev) begin frame_stb = 0; frame_bub = 0; end
        if (CYC_O && STB_O) frame_stb++;
        if (CYC_O && !STB_O) frame_bub++;
        low_seen  = frame_end ? 1'b0 : low_now;
        held_prev = STB_O && !ACK_I;
        dat_prev  = DAT_O;
        cyc_prev  = CYC_O;
      end
    end
  end

  // Drives one frame of n_data accepted samples; called aligned to posedge+1.
  task automatic run_frame(input int n_data, input int gap_pct, input int acklow_pct,
                           input int we_pct, input int stb_gap_at, input int ack_low_at);
    int base, got, cnt, gap_left, low_left;
    bit seen_hi, done, gap_done, low_done;
    cnt = 0;
    while (CYC_O && cnt < 2000) begin @(posedge CLK_I); #1; cnt++; end
    base = ack_total; seen_hi = 0; done = 0; gap_done = 0; low_done = 0;
    gap_left = 0; low_left = 0;
    CYC_I = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      got = ack_total - base;
      if (got >= n_data) begin
        CYC_I = 1'b0; STB_I = 1'b0;
      end else begin
        STB_I = ($urandom_range(0, 99) >= gap_pct);
        WE_I  = ($urandom_range(0, 99) >= we_pct);
        if (!gap_done && stb_gap_at >= 0 && got == stb_gap_at) begin gap_left = 2; gap_done = 1; end
        if (gap_left > 0) begin STB_I = 1'b0; gap_left--; end
      end
      DAT_I = $urandom;
      ACK_I = ($urandom_range(0, 99) >= acklow_pct);
      if (!low_done && ack_low_at >= 0 && got == ack_low_at) begin low_left = 3; low_done = 1; end
      if (low_left > 0) begin ACK_I = 1'b0; low_left--; end
      @(negedge CLK_I);
      if (CYC_O) seen_hi = 1;
      else if (seen_hi) begin done = 1; break; end
      @(posedge CLK_I); #1;
    end
    chk("frame_done", {31'd0, done}, 32'd1);
    @(posedge CLK_I); #1;
    CYC_I = 1'b0; STB_I = 1'b0; ACK_I = 1'b1;
  endtask

  task automatic clear_pilots();
    for (int s = 0; s < 32; s++)
      for (int j = 0; j < 4; j++) pil_log[s][j] = 16'hDEAD;
  endtask

  task automatic chk_pilots(input int s, input bit inv);
    logic [15:0] exp_p;
    for (int j = 0; j < 4; j++) begin
      exp_p = ((j == 3) ^ inv) ? 16'h8001 : 16'h7FFF;
      chk($sformatf("pilot s%0d j%0d", s, j), {16'h0, pil_log[s][j]}, {16'h0, exp_p});
    end
  endtask

  initial begin
    bit inv_tab[8];
    int cnt;
    inv_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("rst_dat", DAT_O, 32'h0);
    chk("rst_stb_cyc_we_ack", {28'd0, STB_O, CYC_O, WE_O, ACK_O}, 32'd0);
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    ACK_I = 1'b1;
    repeat (2) @(posedge CLK_I); #1;

    // One clean frame of 48 samples: 64 back-to-back samples, one start bubble
    clear_pilots();
    run_frame(48, 0, 0, 0, -1, -1);
    chk("clean_stb_cycles", frame_stb, 32'd64);
    chk("clean_bubbles", frame_bub, 32'd1);
    chk("clean_q_empty", q.size(), 32'd0);
    chk_pilots(0, 1'b0);

    // Nine continuous symbols: pilot polarity sequence, no inter-symbol gaps
    clear_pilots();
    run_frame(9 * 48, 0, 0, 0, -1, -1);
    chk("nine_stb_cycles", frame_stb, 32'd576);
    chk("nine_bubbles", frame_bub, 32'd1);
    for (int s = 0; s < 8; s++) chk_pilots(s, inv_tab[s]);

    // Downstream stall of 3 cycles and upstream strobe gap of 2 cycles at pos 28
    run_frame(48, 0, 0, 0, 20, 10);
    chk("stall_stb_cycles", frame_stb, 32'd67);
    chk("stall_bubbles", frame_bub, 32'd3);

    // Early frame end after 30 samples: remaining data slots flushed to zero
    clear_pilots();
    run_frame(30, 0, 0, 0, -1, -1);
    chk("flush_stb_cycles", frame_stb, 32'd64);
    chk_pilots(0, 1'b0);

    // Reset in the middle of a symbol
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ACK_I = 1'b1;
    cnt = 0;
    while (mpos < 40 && cnt < 500) begin DAT_I = $urandom; @(posedge CLK_I); #1; cnt++; end
    chk("reach_pos40", {31'd0, (mpos == 40)}, 32'd1);
    RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0;
    @(negedge CLK_I);
    chk("midrst_dat", DAT_O, 32'h0);
    chk("midrst_ctl", {29'd0, STB_O, CYC_O, ACK_O}, 32'd0);
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("no_restart", {30'd0, CYC_O, STB_O}, 32'd0);
    @(posedge CLK_I); #1;
    clear_pilots();
    run_frame(48, 0, 0, 0, -1, -1);
    chk("after_rst_stb_cycles", frame_stb, 32'd64);
    chk_pilots(0, 1'b0);

    // Randomised frames with strobe gaps, stalls and write-qualifier drops
    for (int f = 0; f < 8; f++)
      run_frame($urandom_range(0, 140), 20, 25, 5, -1, -1);

    repeat (4) @(posedge CLK_I);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
